display_scheduler: RTL and testbench
====================================

Name: display_scheduler

Overview:
- Shares the 4-digit seven-segment display between two requesters (A: primary value, e.g. score; B: secondary, e.g. timer) with a request/grant handshake and a minimum hold time.
- Produces the four BCD digit codes and a scan-rate enable pulse for the seven_segment driver.
- Performs leading-zero blanking, and blanks the display when idle.
- Sits between the game/counter logic and seven_segment.

Parameters:
SCAN_DIV, 50000, clk cycles per scan_tick period (>=2)
HOLD_TICKS, 200, minimum scan_ticks an owner keeps the display once granted (>=1)
BLANK_CODE, 4'hF, digit code emitted for a blank digit (seven_segment shows all segments off for codes >9)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_a  input  1  requester A wants the display
bcd_a  input  16  A's digits, [15:12]=BCD3 (leftmost) .. [3:0]=BCD0
req_b  input  1  requester B wants the display
bcd_b  input  16  B's digits, same packing
lz_blank  input  1  1 = blank leading zeros
gnt_a  output  1  A owns the display
gnt_b  output  1  B owns the display
scan_tick  output  1  one-cycle pulse every SCAN_DIV cycles; digit-scan enable for seven_segment
BCD0  output  4  rightmost digit code
BCD1  output  4  digit code
BCD2  output  4  digit code
BCD3  output  4  leftmost digit code

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst. All outputs registered.
- Reset values: gnt_a=0, gnt_b=0, scan_tick=0, BCD0..BCD3=BLANK_CODE, prescaler=0, hold=0, last_owner=B, state=IDLE.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. scan_tick=1 on the cycle after the count equals SCAN_DIV-1. Free-running in every state; only rst clears it.
- FSM states: IDLE, OWN_A, OWN_B. gnt_a = (state==OWN_A) and gnt_b = (state==OWN_B), so they are never both 1.
- IDLE:
  - only req_a -> OWN_A; only req_b -> OWN_B.
  - both requesting -> the one not equal to last_owner. After reset A wins first.
  - Transition takes effect at the next edge.
- Entry to OWN_x: hold loads HOLD_TICKS, last_owner<=x, and the display register captures bcd_x on the same edge. Grant and new digits appear in the same cycle, one cycle after the request is sampled.
- In OWN_x:
  - hold decrements by 1 on each scan_tick while >0.
  - Display register reloads from bcd_x every cycle while req_x=1. When req_x=0 it freezes at the last value.
- Release is evaluated only when hold==0:
  - other requester asserting -> switch directly to OWN_other. Loads hold and captures data as on entry; no IDLE cycle.
  - else req_x=0 -> IDLE, with digits blanked on the same edge.
  - else stay in OWN_x with hold at 0; re-evaluated every cycle.
- A request dropped before hold expires does not release early. The owner keeps its frozen value until hold==0.
- Simultaneous scan_tick and hold reaching 0: release is evaluated on the following cycle (hold==0 as registered).
- Blanking, applied when loading the display register from the 16-bit source:
  - if lz_blank=1: BCD3=BLANK_CODE if its source is 0; BCD2 likewise if its source is 0 and BCD3 is blanked; BCD1 likewise if its source is 0 and BCD2 is blanked.
  - BCD0 is never blanked by leading-zero logic.
  - Codes 10..15 pass through unchanged.
  - lz_blank is sampled with the data, so a frozen value keeps its blanking.
- Reset mid-ownership: next edge forces all reset values, regardless of hold or requests.

Test Plan:
(Bench parameters SCAN_DIV=4, HOLD_TICKS=2.)
1. Reset: rst=1 for 2 cycles with req_a=req_b=1 -> gnt_a=gnt_b=0, BCD0..3=4'hF, scan_tick=0. After release: gnt_a=1 one cycle after the first sampled request; scan_tick pulses every 4th cycle.
2. Single owner: req_a=1, bcd_a=16'h0042, lz_blank=1 -> BCD3=F, BCD2=F, BCD1=4, BCD0=2. Then bcd_a=16'h1234 -> outputs 1,2,3,4 one cycle later.
3. Leading-zero edge cases: bcd_a=16'h0000 with lz_blank=1 -> F,F,F,0. bcd_a=16'h0102 -> F,1,0,2. Same inputs with lz_blank=0 -> 0,1,0,2.
4. Contention and hold:
   - From IDLE after reset, req_a=req_b=1 -> OWN_A.
   - Stays OWN_A until exactly 2 scan_ticks elapse, then gnt_b=1 with BCD=bcd_b on the same cycle, with no IDLE gap.
   - Next contention from IDLE favours A again, since last_owner=B.
5. Early drop: in OWN_B, drop req_b after 1 scan_tick -> digits frozen and gnt_b held until hold==0, then IDLE with digits all F. If req_a rises during the hold -> direct switch to OWN_A at expiry.
6. Mid-operation reset: rst=1 for one cycle while in OWN_A with hold=1 -> next cycle gnt_a=0 and BCD all F. Prescaler restarts, and the first scan_tick comes 4 cycles after rst falls.

Source files
------------

// File: rtl/display_scheduler.sv
// display_scheduler: shares a 4-digit seven-segment display between two requesters.
//   A (primary) and B (secondary) request the display; the winner is granted for at least
//   HOLD_TICKS scan ticks. Digits are captured with optional leading-zero blanking, and the
//   display is blanked while idle. A free-running prescaler produces the scan enable.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_a, bcd_a        requester A and its four BCD digits ([15:12] leftmost)
//   req_b, bcd_b        requester B and its four BCD digits
//   lz_blank            1 = blank leading zeros when loading digits
//   gnt_a, gnt_b        current owner (never both high)
//   scan_tick           one-cycle pulse every SCAN_DIV cycles
//   BCD3..BCD0          digit codes for seven_segment (BCD3 leftmost)
module display_scheduler #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned HOLD_TICKS = 200,
  parameter logic [3:0]  BLANK_CODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [15:0] bcd_a,
  input  logic        req_b,
  input  logic [15:0] bcd_b,
  input  logic        lz_blank,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        scan_tick,
  output logic [3:0]  BCD0,
  output logic [3:0]  BCD1,
  output logic [3:0]  BCD2,
  output logic [3:0]  BCD3
);

  localparam int unsigned CntW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HoldW = $clog2(HOLD_TICKS + 1);
  localparam logic [CntW-1:0]  CntMax   = CntW'(SCAN_DIV - 1);
  localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_TICKS);
  localparam logic [15:0]      AllBlank = {4{BLANK_CODE}};

  typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

  state_e            state_q, state_d;
  logic              last_b_q, last_b_d;  // last owner was B
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [15:0]       disp_q, disp_d;
  logic [CntW-1:0]   cnt_q;
  logic              tick_q;

  // Leading-zero blanking stops at the first non-zero digit; BCD0 is always shown.
  function automatic logic [15:0] fmt(input logic [15:0] src, input logic en);
    logic b3, b2, b1;
    b3 = en && (src[15:12] == 4'd0);
    b2 = b3 && (src[11:8] == 4'd0);
    b1 = b2 && (src[7:4] == 4'd0);
    return {b3 ? BLANK_CODE : src[15:12],
            b2 ? BLANK_CODE : src[11:8],
            b1 ? BLANK_CODE : src[7:4],
            src[3:0]};
  endfunction

  // Free-running scan prescaler; tick is the registered wrap condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == CntMax);
      cnt_q  <= (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      last_b_q <= 1'b1;
      hold_q   <= '0;
      disp_q   <= AllBlank;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      hold_q   <= hold_d;
      disp_q   <= disp_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    hold_d   = hold_q;
    disp_d   = disp_q;
    case (state_q)
      StIdle: begin
        // On contention the requester that did not own last time wins.
        if (req_a && (!req_b || last_b_q)) begin
          state_d  = StOwnA;
          last_b_d = 1'b0;
          hold_d   = HoldInit;
          disp_d   = fmt(bcd_a, lz_blank);
        end else if (req_b) begin
          state_d  = StOwnB;
          last_b_d = 1'b1;
          hold_d   = HoldInit;
          disp_d   = fmt(bcd_b, lz_blank);
        end
      end
      StOwnA: begin
        if (hold_q != '0) begin
          if (req_a) disp_d = fmt(bcd_a, lz_blank);
          if (tick_q) hold_d = hold_q - HoldW'(1);
        end else if (req_b) begin
          state_d  = StOwnB;
          last_b_d = 1'b1;
          hold_d   = HoldInit;
          disp_d   = fmt(bcd_b, lz_blank);
        end else if (!req_a) begin
          state_d = StIdle;
          disp_d  = AllBlank;
        end else begin
          disp_d = fmt(bcd_a, lz_blank);
        end
      end
      StOwnB: begin
        if (hold_q != '0) begin
          if (req_b) disp_d = fmt(bcd_b, lz_blank);
          if (tick_q) hold_d = hold_q - HoldW'(1);
        end else if (req_a) begin
          state_d  = StOwnA;
          last_b_d = 1'b0;
          hold_d   = HoldInit;
          disp_d   = fmt(bcd_a, lz_blank);
        end else if (!req_b) begin
          state_d = StIdle;
          disp_d  = AllBlank;
        end else begin
          disp_d = fmt(bcd_b, lz_blank);
        end
      end
      default: begin
        state_d = StIdle;
        disp_d  = AllBlank;
      end
    endcase
  end

  // Outputs decode registered state only.
  always_comb begin
    gnt_a     = (state_q == StOwnA);
    gnt_b     = (state_q == StOwnB);
    scan_tick = tick_q;
    BCD3      = disp_q[15:12];
    BCD2      = disp_q[11:8];
    BCD1      = disp_q[7:4];
    BCD0      = disp_q[3:0];
  end

endmodule

// File: tb/tb_display_scheduler.sv
module tb_display_scheduler;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned HOLD     = 2;

  logic        clk = 1'b0;
  logic        rst, req_a, req_b, lz_blank;
  logic [15:0] bcd_a, bcd_b;
  logic        gnt_a, gnt_b, scan_tick;
  logic [3:0]  BCD0, BCD1, BCD2, BCD3;

  display_scheduler #(
    .SCAN_DIV  (SCAN_DIV),
    .HOLD_TICKS(HOLD),
    .BLANK_CODE(4'hF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .bcd_a    (bcd_a),
    .req_b    (req_b),
    .bcd_b    (bcd_b),
    .lz_blank (lz_blank),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .scan_tick(scan_tick),
    .BCD0     (BCD0),
    .BCD1     (BCD1),
    .BCD2     (BCD2),
    .BCD3     (BCD3)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: owner 0=none 1=A 2=B; ticks = scan ticks counted since grant.
  int          m_owner, m_last, m_ticks, m_n;
  logic        m_tick;
  logic [15:0] m_disp;

  typedef struct {
    logic [15:0] bcd;
    logic        lz;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[9];

  function automatic logic [15:0] dig();
    return {BCD3, BCD2, BCD1, BCD0};
  endfunction

  function automatic logic [15:0] shown(input logic [15:0] d, input logic lz);
    logic [15:0] r;
    logic        lead;
    r    = d;
    lead = lz;
    for (int k = 3; k >= 1; k--) begin
      if (lead && d[k*4 +: 4] == 4'd0) r[k*4 +: 4] = 4'hF;
      else lead = 1'b0;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic grant(input int who);
    m_owner = who;
    m_last  = who;
    m_ticks = 0;
    m_disp  = shown((who == 1) ? bcd_a : bcd_b, lz_blank);
  endtask

  task automatic model_step();
    logic tick_pre, my_req, oth_req;
    tick_pre = m_tick;
    if (rst) begin
      m_owner = 0; m_last = 2; m_ticks = 0; m_n = 0; m_tick = 1'b0; m_disp = 16'hFFFF;
      return;
    end
    m_n++;
    m_tick = (m_n % SCAN_DIV == 0);
    if (m_owner == 0) begin
      if (req_a && req_b) grant((m_last == 1) ? 2 : 1);
      else if (req_a) grant(1);
      else if (req_b) grant(2);
    end else begin
      my_req  = (m_owner == 1) ? req_a : req_b;
      oth_req = (m_owner == 1) ? req_b : req_a;
      if (m_ticks >= HOLD && oth_req) begin
        grant(3 - m_owner);
      end else if (m_ticks >= HOLD && !my_req) begin
        m_owner = 0;
        m_disp  = 16'hFFFF;
      end else begin
        if (my_req) m_disp = shown((m_owner == 1) ? bcd_a : bcd_b, lz_blank);
        if (tick_pre && m_ticks < HOLD) m_ticks++;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_gnt_a", gnt_a, m_owner == 1);
    check("model_gnt_b", gnt_b, m_owner == 2);
    check("model_tick", scan_tick, m_tick);
    check("model_bcd", dig(), m_disp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, k;
    vecs[0] = '{16'h0042, 1'b1, 16'hFF42};
    vecs[1] = '{16'h1234, 1'b1, 16'h1234};
    vecs[2] = '{16'h0000, 1'b1, 16'hFFF0};
    vecs[3] = '{16'h0102, 1'b1, 16'hF102};
    vecs[4] = '{16'h0102, 1'b0, 16'h0102};
    vecs[5] = '{16'h00A0, 1'b1, 16'hFFA0};
    vecs[6] = '{16'h0F00, 1'b1, 16'hFF00};
    vecs[7] = '{16'h1000, 1'b1, 16'h1000};
    vecs[8] = '{16'h0000, 1'b0, 16'h0000};

    // Reset with both requesting
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; lz_blank = 1'b1;
    bcd_a = 16'h0042; bcd_b = 16'h0777;
    repeat (2) begin
      cycle();
      check("rst_gnt", {gnt_a, gnt_b}, 0);
      check("rst_bcd", dig(), 16'hFFFF);
      check("rst_tick", scan_tick, 0);
    end

    // Contention after reset: A first, held for exactly two ticks, then B with no gap
    rst = 1'b0;
    cycle();
    check("first_gnt_a", gnt_a, 1);
    check("first_bcd", dig(), 16'hFF42);
    cyc = 1;
    while (!gnt_b && cyc < 40) begin
      cycle();
      cyc++;
      if (!gnt_b) check("hold_a", gnt_a, 1);
    end
    check("switch_cycle", cyc, 10);
    check("switch_gnt_a", gnt_a, 0);
    check("switch_bcd", dig(), 16'hF777);

    // Early drop in OWN_B: digits frozen until hold expires, then idle blank
    req_a = 1'b0;
    k = 0;
    while (!scan_tick && k < 10) begin cycle(); k++; end
    check("tick_seen_b", scan_tick, 1);
    req_b = 1'b0; bcd_b = 16'h1111;
    k = 0;
    while (gnt_b && k < 20) begin
      cycle();
      k++;
      if (gnt_b) check("frozen_b", dig(), 16'hF777);
    end
    check("drop_idle_gnt", {gnt_a, gnt_b}, 0);
    check("drop_idle_bcd", dig(), 16'hFFFF);

    // Next contention favours A since B owned last
    req_a = 1'b1; req_b = 1'b1;
    cycle();
    check("recontend_a", gnt_a, 1);
    k = 0;
    while (!gnt_b && k < 20) begin cycle(); k++; end
    check("recontend_b", gnt_b, 1);

    // A rises during B's hold after B drops: direct switch at expiry
    req_a = 1'b0; req_b = 1'b0; bcd_a = 16'h0305;
    k = 0;
    while (!scan_tick && k < 10) begin cycle(); k++; end
    req_a = 1'b1;
    k = 0;
    while (gnt_b && k < 20) begin cycle(); k++; end
    check("direct_gnt_a", gnt_a, 1);
    check("direct_bcd", dig(), 16'hF305);

    // Table: digit formatting while A owns and requests continuously
    req_b = 1'b0;
    foreach (vecs[i]) begin
      bcd_a = vecs[i].bcd; lz_blank = vecs[i].lz;
      cycle();
      check("vec_gnt", gnt_a, 1);
      check("vec_bcd", dig(), vecs[i].exp);
    end

    // Mid-ownership reset with hold=1
    req_a = 1'b0; lz_blank = 1'b1;
    k = 0;
    while (gnt_a && k < 20) begin cycle(); k++; end
    check("idle_before_rst", gnt_a, 0);
    req_a = 1'b1;
    cycle();
    check("regrant_a", gnt_a, 1);
    k = 0;
    while (!scan_tick && k < 10) begin cycle(); k++; end
    cycle();
    rst = 1'b1;
    cycle();
    check("midrst_gnt", {gnt_a, gnt_b}, 0);
    check("midrst_bcd", dig(), 16'hFFFF);
    check("midrst_tick", scan_tick, 0);
    rst = 1'b0;
    k = 0;
    do begin cycle(); k++; end while (!scan_tick && k < 10);
    check("tick_after_rst", k, 4);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) req_a = ~req_a;
      if ($urandom_range(0, 7) == 0) req_b = ~req_b;
      if ($urandom_range(0, 3) == 0) lz_blank = ~lz_blank;
      for (int d = 0; d < 4; d++) begin
        bcd_a[d*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        bcd_b[d*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
